// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers, field positions and exception codes
package cp0_pkg;
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;
  localparam int IM_LO  = 10;
  localparam int IM_HI  = 15;
  localparam int EXL    = 1;
  localparam int IE     = 0;
  localparam int BD     = 31;
  localparam int EXC_LO = 2;
  localparam int EXC_HI = 6;
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } excCode_t;
endpackage

// File: rtl/cp0_int_sync.sv
// cp0_int_sync: two-flop synchroniser for the external interrupt lines
module cp0_int_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] hwint,
  output logic [5:0] ip
);
  logic [5:0] meta;
  // first flop may go metastable; second flop presents a settled level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {ip, meta} <= '0;
    else {ip, meta} <= {meta, hwint};
endmodule

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: CP0 registers plus interrupt/exception request arbitration
module cp0_exc_unit import cp0_pkg::*; #(
  parameter logic [31:0] PRID       = 32'h2023_0001,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  hwint,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic        exc_valid_m,
  input  logic [4:0]  exccode_m,
  input  logic        eret_m,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        int_req,
  output logic [31:0] epc,
  output logic        exl,
  output logic [31:0] exc_vector
);
  logic [5:0]  ip;
  logic [5:0]  im;
  logic        ie;
  logic        bd;
  logic [4:0]  excCode;
  logic [31:0] epcReg;
  logic        intPend;
  logic        srWr;
  logic        epcWr;
  logic [31:0] epcNext;

  cp0_int_sync uSync (
    .clk  (clk),
    .rst_n(rst_n),
    .hwint(hwint),
    .ip   (ip)
  );

  assign intPend    = (|(ip & im)) & ie & ~exl;
  assign int_req    = intPend | (exc_valid_m & ~exl);
  assign srWr       = we && addr == REG_SR;
  assign epcWr      = we && addr == REG_EPC;
  assign epcNext    = (bd_m ? pc_m - 32'd4 : pc_m) & ~32'd3;
  assign epc        = (epcWr && !int_req) ? wdata : epcReg;
  assign exc_vector = EXC_VECTOR;

  // exception entry owns EXL/Cause/EPC; mtc0 still lands on IM/IE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      im      <= '0;
      ie      <= 1'b0;
      exl     <= 1'b0;
      bd      <= 1'b0;
      excCode <= '0;
      epcReg  <= '0;
    end else begin
      if (srWr) begin
        im <= wdata[IM_HI:IM_LO];
        ie <= wdata[IE];
      end
      if (int_req) begin
        exl     <= 1'b1;
        bd      <= bd_m;
        excCode <= intPend ? EXC_INT : exccode_m;
        epcReg  <= epcNext;
      end else begin
        if (srWr) exl <= wdata[EXL];
        if (eret_m) exl <= 1'b0;
        if (epcWr) epcReg <= wdata;
      end
    end

  // mfc0 read mux; unmapped bits and registers read as zero
  always_comb begin
    rdata = '0;
    case (addr)
      REG_SR: begin
        rdata[IM_HI:IM_LO] = im;
        rdata[EXL]         = exl;
        rdata[IE]          = ie;
      end
      REG_CAUSE: begin
        rdata[BD]            = bd;
        rdata[IM_HI:IM_LO]   = ip;
        rdata[EXC_HI:EXC_LO] = excCode;
      end
      REG_EPC:  rdata = epcReg;
      REG_PRID: rdata = PRID;
      default:  rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb_cp0_exc_unit: directed plan plus randomized run against a register-level model
module tb_cp0_exc_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  hwint = '0;
  logic [31:0] pc_m = '0;
  logic        bd_m = 1'b0;
  logic        exc_valid_m = 1'b0;
  logic [4:0]  exccode_m = '0;
  logic        eret_m = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        int_req;
  logic [31:0] epc;
  logic        exl;
  logic [31:0] exc_vector;
  int nChecks = 0;
  int nFail = 0;
  logic [31:0] mSr;
  logic [31:0] mEpc;
  logic        mBd;
  logic [4:0]  mExc;
  logic [5:0]  mIp;
  logic [5:0]  mIpStage;

  always #5 clk = ~clk;

  cp0_exc_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hwint      (hwint),
    .pc_m       (pc_m),
    .bd_m       (bd_m),
    .exc_valid_m(exc_valid_m),
    .exccode_m  (exccode_m),
    .eret_m     (eret_m),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .int_req    (int_req),
    .epc        (epc),
    .exl        (exl),
    .exc_vector (exc_vector)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic mIntr();
    return ((mIp & mSr[15:10]) != 6'd0) && mSr[0] && !mSr[1];
  endfunction

  function automatic logic mReq();
    return mIntr() || (exc_valid_m && !mSr[1]);
  endfunction

  function automatic logic [31:0] mRead(input logic [4:0] a);
    case (a)
      5'd12: return mSr;
      5'd13: return ({31'd0, mBd} << 31) | ({26'd0, mIp} << 10) | ({27'd0, mExc} << 2);
      5'd14: return mEpc;
      5'd15: return 32'h2023_0001;
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelReset();
    mSr = '0; mEpc = '0; mBd = 1'b0; mExc = '0; mIp = '0; mIpStage = '0;
  endtask

  task automatic modelEdge();
    logic intr, ir;
    intr = mIntr();
    ir = mReq();
    if (we && addr == 5'd12)
      mSr = ir ? ((wdata & 32'h0000_FC01) | (mSr & 32'h2)) : (wdata & 32'h0000_FC03);
    if (ir) begin
      mSr |= 32'h2;
      mBd = bd_m;
      mExc = intr ? 5'd0 : exccode_m;
      mEpc = (bd_m ? pc_m - 32'd4 : pc_m) & 32'hFFFF_FFFC;
    end else begin
      if (eret_m) mSr &= ~32'h2;
      if (we && addr == 5'd14) mEpc = wdata;
    end
    mIp = mIpStage;
    mIpStage = hwint;
  endtask

  task automatic tick();
    #1;
    chk("int_req", {31'd0, int_req}, {31'd0, mReq()});
    chk("rdata", rdata, mRead(addr));
    chk("epc", epc, (we && addr == 5'd14 && !mReq()) ? wdata : mEpc);
    chk("exl", {31'd0, exl}, {31'd0, mSr[1]});
    @(posedge clk);
    if (rst_n) modelEdge();
    @(negedge clk);
  endtask

  task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    logic [31:0] rstVals [4];
    logic [4:0] codes [5];
    rstVals = '{32'd0, 32'd0, 32'd0, 32'h2023_0001};
    codes = '{5'd0, 5'd4, 5'd5, 5'd10, 5'd12};
    modelReset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) peek("rst_read", 5'(12 + i), rstVals[i]);
    @(negedge clk);
    chk("rst_int_req", {31'd0, int_req}, 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_exl", {31'd0, exl}, 32'd0);
    chk("exc_vector", exc_vector, 32'h0000_4180);
    rst_n = 1'b1;
    @(negedge clk);
    // interrupt latency through the synchroniser
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401; hwint = 6'h01; pc_m = 32'h0000_2000;
    tick();
    we = 1'b0; addr = 5'd13;
    #1 chk("irq_cycle1", {31'd0, int_req}, 32'd0);
    tick();
    #1 chk("irq_cycle2", {31'd0, int_req}, 32'd1);
    tick();
    peek("sr_after_int", 5'd12, 32'h0000_0403);
    tick();
    peek("cause_after_int", 5'd13, 32'h0000_0400);
    tick();
    peek("epc_after_int", 5'd14, 32'h0000_2000);
    tick();
    // EXL blocks, eret releases, interrupt beats a sync exception
    exc_valid_m = 1'b1; exccode_m = 5'd12;
    #1 chk("exl_blocks", {31'd0, int_req}, 32'd0);
    tick();
    exc_valid_m = 1'b0; eret_m = 1'b1;
    tick();
    eret_m = 1'b0;
    chk("eret_clears", {31'd0, exl}, 32'd0);
    exc_valid_m = 1'b1; exccode_m = 5'd10; pc_m = 32'h0000_2104;
    #1 chk("irq_after_eret", {31'd0, int_req}, 32'd1);
    tick();
    exc_valid_m = 1'b0;
    peek("cause_prio", 5'd13, 32'h0000_0400);
    tick();
    peek("epc_prio", 5'd14, 32'h0000_2104);
    tick();
    // branch-delay-slot sync exception
    hwint = 6'h00; we = 1'b1; addr = 5'd12; wdata = 32'h0000_0001;
    tick();
    we = 1'b0;
    tick();
    tick();
    exc_valid_m = 1'b1; exccode_m = 5'd12; bd_m = 1'b1; pc_m = 32'h0000_3008;
    #1 chk("exc_req", {31'd0, int_req}, 32'd1);
    tick();
    exc_valid_m = 1'b0; bd_m = 1'b0;
    peek("epc_bd", 5'd14, 32'h0000_3004);
    tick();
    peek("cause_bd", 5'd13, 32'h8000_0030);
    tick();
    // EPC bypass alongside eret
    we = 1'b1; addr = 5'd14; wdata = 32'h0000_3100; eret_m = 1'b1;
    #1 chk("epc_bypass", epc, 32'h0000_3100);
    tick();
    we = 1'b0; eret_m = 1'b0;
    peek("sr_after_eret", 5'd12, 32'h0000_0001);
    tick();
    // asynchronous reset mid-handler
    exc_valid_m = 1'b1; exccode_m = 5'd4; pc_m = 32'h0000_5000; addr = 5'd14;
    tick();
    exc_valid_m = 1'b0;
    #1 chk("handler_exl", {31'd0, exl}, 32'd1);
    rst_n = 1'b0;
    #1 chk("async_rst_exl", {31'd0, exl}, 32'd0);
    chk("async_rst_epc", epc, 32'd0);
    modelReset();
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    // randomized run
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) hwint = hwint ^ 6'($urandom_range(0, 63));
      we = ($urandom_range(0, 3) == 0);
      addr = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(12, 15));
      wdata = $urandom;
      pc_m = ($urandom_range(0, 31) == 0) ? 32'd0 : ($urandom & 32'hFFFF_FFFC);
      bd_m = $urandom_range(0, 1) == 1;
      exc_valid_m = ($urandom_range(0, 7) == 0);
      exccode_m = codes[$urandom_range(0, 4)];
      eret_m = ($urandom_range(0, 7) == 0);
      if (eret_m && we && addr == 5'd12) we = 1'b0;
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule

// File: doc/cp0_exc_unit.md
# cp0_exc_unit

Coprocessor-0 register file and exception/interrupt request generator for the five-stage MIPS pipeline. Holds SR, Cause, EPC and PRId. Synchronises six external hardware interrupt lines and arbitrates them against synchronous exceptions reported from the M stage. Drives the single request, EPC value and EXL status consumed by the pipeline flush/redirect controller.

## Interface
Parameters:
- PRID, 32'h2023_0001, constant returned on reads of PRId.
- EXC_VECTOR, 32'h0000_4180, handler address, exported for the PC mux.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hwint  in  6  external interrupt lines, asynchronous, level-sensitive.
- pc_m  in  32  PC of the instruction in M; always a valid macro PC, bubbles carry the next real PC.
- bd_m  in  1  M instruction is in a branch delay slot.
- exc_valid_m  in  1  synchronous exception detected for the M instruction.
- exccode_m  in  5  ExcCode of that exception.
- eret_m  in  1  eret in M.
- we  in  1  mtc0 write strobe.
- addr  in  5  CP0 register number for mtc0/mfc0.
- wdata  in  32  mtc0 data.
- rdata  out  32  mfc0 data; combinational from addr.
- int_req  out  1  take exception/interrupt this cycle; combinational.
- epc  out  32  return address for eret.
- exl  out  1  SR.EXL.
- exc_vector  out  32  equals EXC_VECTOR.

## Operation
- Register map: 12 SR (IM[15:10], EXL[1], IE[0]); 13 Cause (BD[31], IP[15:10] read-only, ExcCode[6:2]); 14 EPC; 15 PRId (read-only). Unlisted bits and addresses read 0; writes to them are ignored.
- IP[15:10] is the output of the hwint synchroniser, updated every cycle. It is not latched.
- int_pend = |(IP & IM) & IE & !EXL.
- int_req = int_pend | (exc_valid_m & !EXL).
- Priority: interrupt over synchronous exception. On an interrupt, ExcCode = 0.
- On int_req, next edge:
  - EXL <= 1.
  - Cause.BD <= bd_m.
  - Cause.ExcCode <= interrupt ? 0 : exccode_m.
  - EPC <= bd_m ? {pc_m-4}[31:2],2'b00 : {pc_m[31:2],2'b00}.
- eret_m without int_req: next edge EXL <= 0. If eret_m and int_req coincide, int_req wins and EXL stays 1.
- mtc0 (we) applies at the edge to SR/EPC unless int_req is high the same cycle. In that case the exception update wins for EXL, Cause and EPC. An mtc0 to SR still writes IM/IE. Writes to Cause change no fields.
- epc output: if we & addr==14 & !int_req, epc = wdata (bypass); otherwise epc = EPC register.
- PC arithmetic is modulo 2^32.

## Timing
- Reset values: SR = 0, Cause = 0, EPC = 0, synchroniser flops = 0. Outputs after reset: rdata depends on addr; int_req = 0; epc = 0; exl = 0.
- Reset is asynchronous. Asserting it mid-handler clears EXL and all pending state immediately.
- hwint latency: a line rising before edge k is visible in IP after edge k+1. int_req asserts in cycle k+1, provided IM, IE and !EXL hold.
- Deasserting a line drops IP two edges later. No pending state is retained.
- int_req, rdata and epc are combinational. All register effects are visible from the cycle after the edge.
- EXL set blocks a second int_req from the cycle after entry until the cycle after eret.

## Structure
- Shared package cp0_pkg holds:
  - register numbers SR/CAUSE/EPC/PRID;
  - bit positions IM_LO/IM_HI/EXL/IE/BD/EXC_LO/EXC_HI;
  - ExcCode constants (INT=0, ADEL=4, ADES=5, RI=10, OV=12).
- Sub-module cp0_int_sync: 6-bit two-flop synchroniser with async active-low clear.
- Remaining logic stays in cp0_exc_unit.

## Test plan
- Reset, then mfc0 from addr 12/13/14/15 -> rdata 0, 0, 0, 32'h2023_0001; int_req 0.
- mtc0 SR=32'h0000_0401, hold hwint[0]=1 from edge 0 -> int_req 1 in cycle 2. Next edge: EXL 1, Cause.ExcCode 0, EPC = pc_m.
- exc_valid_m=1, exccode_m=12, bd_m=1, pc_m=32'h0000_3008 -> int_req 1 same cycle. After edge: EPC 32'h0000_3004, Cause = 32'h8000_0030.
- Same cycle: interrupt pending, exc_valid_m=1, exccode_m=10 -> ExcCode 0 (interrupt wins); EPC = pc_m.
- With EXL=1: exc_valid_m=1 -> int_req 0. Then eret_m -> EXL 0 after the edge. Pending interrupt -> int_req 1 the cycle after that.
- we=1, addr=14, wdata=32'h0000_3100 with eret_m -> epc 32'h0000_3100 same cycle. Assert rst_n=0 mid-handler -> exl 0 immediately, EPC 0.
